// File: rtl/lock_supervisor_if.sv
// Handshake and lock-side signal bundle for lock_supervisor.
// The slave modport is the supervisor's view. The master modport is the keypad/LOCK side.
interface lock_supervisor_if #(
    parameter int CODE_W = 8,
    parameter int FC_W   = 2
);
    logic              code_valid;
    logic [CODE_W-1:0] code_data;
    logic              code_ready;
    logic              lock_in;
    logic              lock_rst;
    logic              lock_open;
    logic              lock_alarm;
    logic              door_unlock;
    logic              lockout;
    logic [FC_W-1:0]   fail_count;
    logic              result_valid;
    logic              result_pass;

    modport slave (
        input  code_valid, code_data, lock_open, lock_alarm,
        output code_ready, lock_in, lock_rst, door_unlock, lockout,
               fail_count, result_valid, result_pass
    );

    modport master (
        output code_valid, code_data, lock_open, lock_alarm,
        input  code_ready, lock_in, lock_rst, door_unlock, lockout,
               fail_count, result_valid, result_pass
    );
endinterface

// File: rtl/lock_supervisor.sv
// Sequences a serial-code LOCK: accept code, clear lock, shift code MSB-first,
// judge the response, then hold the door open or count failures and enforce lockout.
module lock_supervisor #(
    parameter int   CODE_W      = 8,
    parameter int   MAX_FAIL    = 3,
    parameter int   FC_W        = 2,
    parameter int   RESP_CYC    = 4,
    parameter int   HOLD_CYC    = 16,
    parameter int   LOCKOUT_CYC = 64,
    parameter logic IDLE_BIT    = 1'b0,
    parameter int   TMR_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    lock_supervisor_if.slave  bus
);
    localparam int BC_W = $clog2(CODE_W + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CLR, S_SHIFT, S_WAIT, S_PASS, S_FAIL, S_LOCKOUT
    } state_e;

    state_e            state_q, state_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic              alarm_q, alarm_d;
    logic [FC_W-1:0]   fail_count_q, fail_count_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            timer_q      <= '0;
            bit_cnt_q    <= '0;
            code_q       <= '0;
            alarm_q      <= 1'b0;
            fail_count_q <= '0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            bit_cnt_q    <= bit_cnt_d;
            code_q       <= code_d;
            alarm_q      <= alarm_d;
            fail_count_q <= fail_count_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        bit_cnt_d    = bit_cnt_q;
        code_d       = code_q;
        alarm_d      = alarm_q;
        fail_count_d = fail_count_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.code_valid) begin
                    code_d  = bus.code_data;
                    state_d = S_CLR;
                end
            end
            S_CLR: begin
                alarm_d   = 1'b0;
                bit_cnt_d = '0;
                state_d   = S_SHIFT;
            end
            S_SHIFT: begin
                // The code register shifts so that its MSB is always the bit on lock_in.
                if (bus.lock_alarm) alarm_d = 1'b1;
                code_d    = code_q << 1;
                bit_cnt_d = bit_cnt_q + BC_W'(1);
                if (bit_cnt_q == BC_W'(CODE_W - 1)) begin
                    state_d = S_WAIT;
                    timer_d = '0;
                end
            end
            S_WAIT: begin
                if (alarm_q || bus.lock_alarm || (!bus.lock_open && timer_q == TMR_W'(RESP_CYC - 1))) begin
                    state_d      = S_FAIL;
                    timer_d      = '0;
                    fail_count_d = (fail_count_q == FC_W'(MAX_FAIL)) ? fail_count_q
                                                                     : fail_count_q + FC_W'(1);
                end else if (bus.lock_open) begin
                    state_d      = S_PASS;
                    timer_d      = '0;
                    fail_count_d = '0;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            S_PASS: begin
                if (timer_q == TMR_W'(HOLD_CYC - 1)) state_d = S_IDLE;
                else                                  timer_d = timer_q + TMR_W'(1);
            end
            S_FAIL: begin
                timer_d = '0;
                state_d = (fail_count_q == FC_W'(MAX_FAIL)) ? S_LOCKOUT : S_IDLE;
            end
            S_LOCKOUT: begin
                if (timer_q == TMR_W'(LOCKOUT_CYC - 1)) begin
                    state_d      = S_IDLE;
                    fail_count_d = '0;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.code_ready   = (state_q == S_IDLE);
    assign bus.lock_rst     = rst || (state_q == S_CLR);
    assign bus.lock_in      = (state_q == S_SHIFT) ? code_q[CODE_W-1] : IDLE_BIT;
    assign bus.door_unlock  = (state_q == S_PASS);
    assign bus.lockout      = (state_q == S_LOCKOUT);
    assign bus.fail_count   = fail_count_q;
    assign bus.result_valid = (state_q == S_FAIL) || (state_q == S_PASS && timer_q == '0);
    assign bus.result_pass  = (state_q == S_PASS && timer_q == '0);
endmodule

// File: doc/lock_supervisor.md
Name: lock_supervisor

Overview:
Controller that sequences the serial-code LOCK FSM. It accepts a parallel code word over a valid/ready handshake and clears the lock. It then shifts the code into the lock MSB-first, one bit per clock, and judges the lock's openlock/alarm response. It also holds the door unlocked for a fixed time, counts consecutive failures and enforces a timed lockout, and sits between the keypad/front-end and the LOCK instance.

Parameters:
CODE_W, 8, code length in bits shifted into the lock
MAX_FAIL, 3, consecutive failures that trigger lockout (1..2^FC_W-1)
FC_W, 2, width of fail_count
RESP_CYC, 4, WAIT window in cycles for a lock response (>=1)
HOLD_CYC, 16, cycles door_unlock stays high after a pass (>=1)
LOCKOUT_CYC, 64, cycles of lockout (>=1)
IDLE_BIT, 0, value driven on lock_in outside SHIFT
TMR_W, 8, timer width; must hold max(RESP_CYC, HOLD_CYC, LOCKOUT_CYC)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous, active-high reset
code_valid  in  1  code word offered
code_data  in  CODE_W  code word, bit CODE_W-1 shifted first
code_ready  out  1  high only in IDLE; transfer when code_valid & code_ready
lock_in  out  1  serial bit to LOCK in
lock_rst  out  1  reset to LOCK rst
lock_open  in  1  LOCK openlock
lock_alarm  in  1  LOCK alarm
door_unlock  out  1  door actuator enable
lockout  out  1  high throughout LOCKOUT
fail_count  out  FC_W  consecutive failure count
result_valid  out  1  one-cycle pulse at each verdict
result_pass  out  1  verdict, meaningful when result_valid=1

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE, timers=0, fail_count=0, sticky alarm=0, code register=0.
  - door_unlock=0, lockout=0, result_valid=0, result_pass=0, lock_in=IDLE_BIT.
  - lock_rst = rst OR (state==CLR), combinational, so the LOCK is held reset while rst is high.
  - rst mid-operation aborts at once; no verdict pulse is produced.
- States:
  - IDLE -> CLR on handshake; code_data is registered at that edge. code_valid is ignored in every other state.
  - CLR: 1 cycle; lock_rst=1, lock_in=IDLE_BIT; clears the sticky alarm.
  - SHIFT: exactly CODE_W cycles; lock_in = code bit, MSB first, one bit per cycle. lock_alarm=1 sampled here sets the sticky alarm; lock_open is ignored (prefix).
  - WAIT: up to RESP_CYC cycles; lock_in=IDLE_BIT.
    - Sticky alarm set, or lock_alarm=1 sampled -> FAIL. Alarm wins over a simultaneous lock_open.
    - Otherwise lock_open=1 -> PASS.
    - If the RESP_CYC-th WAIT cycle passes with neither -> FAIL (timeout).
  - PASS (OPEN_HOLD): door_unlock=1 for exactly HOLD_CYC cycles; fail_count cleared on entry; then -> IDLE.
  - FAIL: 1 cycle; fail_count increments, saturating at MAX_FAIL. If the new count == MAX_FAIL -> LOCKOUT, else -> IDLE.
  - LOCKOUT: lockout=1 for exactly LOCKOUT_CYC cycles; code_ready=0; on exit fail_count cleared -> IDLE.
- result_valid=1 in the first PASS cycle (result_pass=1) and in the FAIL cycle (result_pass=0); 0 elsewhere.
- Latency: handshake at edge 0 -> CLR cycle 1 -> SHIFT cycles 2..CODE_W+1 -> first WAIT cycle CODE_W+2.
- All outputs are registered state decodes except lock_rst.
- Back-to-back codes: a new code is accepted the cycle IDLE is re-entered.

Test Plan:
1. Bench lock model opens on 8'hD8 and alarms otherwise. Offer 8'hD8 at cycle 0, model asserts lock_open in cycle 10 -> lock_rst=1 in cycle 1 only; lock_in = 1,1,0,1,1,0,0,0 in cycles 2..9; result_valid=1 and result_pass=1 in cycle 11; door_unlock high in cycles 11..26; code_ready returns high in cycle 27.
2. Offer 8'h55 three times back-to-back with the model alarming in the first WAIT cycle -> fail_count 1, 2, 3, each verdict with result_pass=0; lockout=1 for 64 cycles after the third; code_valid held high is not accepted; fail_count=0 after exit.
3. Model asserts lock_alarm in SHIFT cycle 5, then lock_open in WAIT -> verdict fail (sticky alarm); lock_open and lock_alarm both high in one WAIT cycle -> fail.
4. Model never responds -> FAIL in the cycle after the 4th WAIT cycle (cycle 14); fail_count=1.
5. Two fails, then a pass -> fail_count clears to 0 on PASS entry; a following fail gives fail_count=1, with no lockout.
6. rst asserted in SHIFT cycle 4 and in LOCKOUT cycle 30 -> next cycle IDLE, all outputs at reset values, lock_rst high while rst=1, no result_valid pulse.
